// File: rtl/alu_seq_display_if.sv
// Operand/result handshake bundle for alu_seq_display.
// The master drives operands and start; the slave returns status and result.
interface alu_seq_display_if #(
   parameter int WIDTH = 4
);
   logic [WIDTH-1:0] portA;
   logic [WIDTH-1:0] portB;
   logic [2:0]       opcode;
   logic             start;
   logic             busy;
   logic             done;
   logic             err;
   logic [15:0]      visualizar;

   modport master (
      output portA, portB, opcode, start,
      input  busy, done, err, visualizar
   );

   modport slave (
      input  portA, portB, opcode, start,
      output busy, done, err, visualizar
   );
endinterface

// File: rtl/alu_seq_display.sv
// Sequential ALU with shift-add multiply, restoring divide and a
// multiplexed 4-digit active-low seven-segment hex display of the last result.
module alu_seq_display #(
   parameter int WIDTH        = 4,
   parameter int REFRESH_BITS = 16
) (
   input  logic             clk,
   input  logic             rst,
   alu_seq_display_if.slave bus,
   output logic [0:6]       sevenseg,
   output logic [3:0]       anode
);
   localparam int RW = 2*WIDTH;
   localparam int CW = $clog2(WIDTH+1);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   typedef enum logic [2:0] {
      OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_AND, OP_OR, OP_XOR, OP_CMP
   } op_t;

   state_t                  state_q, state_d;
   op_t                     op_q, op_d;
   logic [WIDTH-1:0]        a_q, a_d, b_q, b_d;
   logic [WIDTH-1:0]        shreg_q, shreg_d, rem_q, rem_d;
   logic [RW-1:0]           prod_q, prod_d, mcand_q, mcand_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic                    busy_q, busy_d, done_q, done_d, err_q, err_d;
   logic [15:0]             vis_q, vis_d;
   logic [REFRESH_BITS-1:0] ref_q, ref_d;
   logic [3:0]              anode_q, anode_d;
   logic [0:6]              seg_q, seg_d;
   logic [RW-1:0]           result;
   logic [WIDTH:0]          trial;
   logic [1:0]              idx;
   logic [3:0]              nib;

   // shreg holds the multiplier (shifted right) for mul, or the dividend
   // turning into the quotient (shifted left) for div.
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      shreg_d = shreg_q;
      rem_d   = rem_q;
      prod_d  = prod_q;
      mcand_d = mcand_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      err_d   = err_q;
      vis_d   = vis_q;
      trial   = {rem_q, shreg_q[WIDTH-1]} - {1'b0, b_q};

      case (op_q)
         OP_ADD:  result = RW'(a_q) + RW'(b_q);
         OP_SUB:  result = RW'(a_q) - RW'(b_q);
         OP_MUL:  result = prod_q;
         OP_DIV:  result = {rem_q, shreg_q};
         OP_AND:  result = RW'(a_q & b_q);
         OP_OR:   result = RW'(a_q | b_q);
         OP_XOR:  result = RW'(a_q ^ b_q);
         default: result = RW'({a_q > b_q, a_q == b_q, a_q < b_q});
      endcase

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               op_d    = op_t'(bus.opcode);
               a_d     = bus.portA;
               b_d     = bus.portB;
               err_d   = 1'b0;
               prod_d  = '0;
               mcand_d = RW'(bus.portA);
               rem_d   = '0;
               cnt_d   = '0;
               shreg_d = (op_d == OP_MUL) ? bus.portB : bus.portA;
               if (op_d == OP_MUL || (op_d == OP_DIV && bus.portB != '0)) begin
                  state_d = CALC;
                  busy_d  = 1'b1;
               end else begin
                  state_d = DONE;
                  // Divide by zero: quotient saturates, remainder is the dividend.
                  if (op_d == OP_DIV) begin
                     shreg_d = '1;
                     rem_d   = bus.portA;
                  end
               end
            end
         end
         CALC: begin
            cnt_d = cnt_q + 1'b1;
            if (op_q == OP_MUL) begin
               if (shreg_q[0]) prod_d = prod_q + mcand_q;
               mcand_d = mcand_q << 1;
               shreg_d = shreg_q >> 1;
            end else begin
               shreg_d = {shreg_q[WIDTH-2:0], ~trial[WIDTH]};
               rem_d   = trial[WIDTH] ? {rem_q[WIDTH-2:0], shreg_q[WIDTH-1]}
                                      : trial[WIDTH-1:0];
            end
            if (cnt_q == CW'(WIDTH-1)) begin
               busy_d  = 1'b0;
               state_d = DONE;
            end
         end
         DONE: begin
            vis_d   = 16'(result);
            done_d  = 1'b1;
            err_d   = (op_q == OP_DIV) && (b_q == '0);
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      ref_d = ref_q + 1'b1;
      idx   = ref_q[REFRESH_BITS-1 -: 2];
      case (idx)
         2'd0:    nib = vis_q[3:0];
         2'd1:    nib = vis_q[7:4];
         2'd2:    nib = vis_q[11:8];
         default: nib = vis_q[15:12];
      endcase
      anode_d = ~(4'b0001 << idx);
      case (nib)
         4'h0:    seg_d = 7'b0000001;
         4'h1:    seg_d = 7'b1001111;
         4'h2:    seg_d = 7'b0010010;
         4'h3:    seg_d = 7'b0000110;
         4'h4:    seg_d = 7'b1001100;
         4'h5:    seg_d = 7'b0100100;
         4'h6:    seg_d = 7'b0100000;
         4'h7:    seg_d = 7'b0001111;
         4'h8:    seg_d = 7'b0000000;
         4'h9:    seg_d = 7'b0000100;
         4'hA:    seg_d = 7'b0001000;
         4'hB:    seg_d = 7'b1100000;
         4'hC:    seg_d = 7'b0110001;
         4'hD:    seg_d = 7'b1000010;
         4'hE:    seg_d = 7'b0110000;
         default: seg_d = 7'b0111000;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         op_q    <= OP_ADD;
         a_q     <= '0;
         b_q     <= '0;
         shreg_q <= '0;
         rem_q   <= '0;
         prod_q  <= '0;
         mcand_q <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         vis_q   <= '0;
         ref_q   <= '0;
         anode_q <= 4'b1110;
         seg_q   <= 7'b0000001;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         shreg_q <= shreg_d;
         rem_q   <= rem_d;
         prod_q  <= prod_d;
         mcand_q <= mcand_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
         vis_q   <= vis_d;
         ref_q   <= ref_d;
         anode_q <= anode_d;
         seg_q   <= seg_d;
      end
   end

   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.err        = err_q;
   assign bus.visualizar = vis_q;
   assign sevenseg       = seg_q;
   assign anode          = anode_q;
endmodule

// File: tb/tb_alu_seq_display.sv
// Scoreboard bench for alu_seq_display (WIDTH=4, REFRESH_BITS=4): results
// are predicted at start time and matched when done pulses.
module tb_alu_seq_display;
   logic       clk;
   logic       rst;
   logic [0:6] sevenseg;
   logic [3:0] anode;
   int         n_checks = 0;
   int         n_fail   = 0;

   typedef struct {
      logic [15:0] vis;
      logic        err;
   } exp_t;
   exp_t sb[$];

   alu_seq_display_if #(.WIDTH(4)) bus();

   alu_seq_display #(.WIDTH(4), .REFRESH_BITS(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .sevenseg (sevenseg),
      .anode    (anode)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
      exp_t e;
      e.err = 1'b0;
      case (op)
         3'd0: e.vis = 16'(a) + 16'(b);
         3'd1: e.vis = (16'(a) - 16'(b)) & 16'h00FF;
         3'd2: e.vis = 16'(a) * 16'(b);
         3'd3: begin
            if (b == 4'd0) begin
               e.vis = {8'h00, a, 4'hF};
               e.err = 1'b1;
            end else begin
               e.vis = {8'h00, 4'(a % b), 4'(a / b)};
            end
         end
         3'd4: e.vis = 16'(a & b);
         3'd5: e.vis = 16'(a | b);
         3'd6: e.vis = 16'(a ^ b);
         default: e.vis = {13'd0, a > b, a == b, a < b};
      endcase
      return e;
   endfunction

   function automatic logic [0:6] seg_of(input logic [3:0] n);
      case (n)
         4'h0:    return 7'b0000001;
         4'h1:    return 7'b1001111;
         4'h8:    return 7'b0000000;
         4'hE:    return 7'b0110000;
         4'hF:    return 7'b0111000;
         default: return 7'bxxxxxxx;
      endcase
   endfunction

   always @(negedge clk) begin : monitor
      exp_t e;
      if (rst && bus.done) begin
         if (sb.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            check("visualizar", 32'(bus.visualizar), 32'(e.vis));
            check("err", 32'(bus.err), 32'(e.err));
         end
      end
   end

   task automatic do_op(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op,
                        input bit inject);
      int exp_lat;
      int lat;
      int busy_cnt;
      bit seen;
      exp_lat = (op == 3'd2 || (op == 3'd3 && b != 4'd0)) ? 5 : 1;
      @(negedge clk);
      bus.portA  = a;
      bus.portB  = b;
      bus.opcode = op;
      bus.start  = 1'b1;
      sb.push_back(model(a, b, op));
      @(posedge clk);
      #1;
      bus.start  = 1'b0;
      bus.portA  = 4'($urandom);
      bus.portB  = 4'($urandom);
      bus.opcode = 3'($urandom);
      @(negedge clk);
      check("err_clr", 32'(bus.err), 32'd0);
      check("no_early_done", 32'(bus.done), 32'd0);
      busy_cnt = int'(bus.busy);
      lat  = 0;
      seen = 1'b0;
      while (!seen && lat < 20) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         busy_cnt += int'(bus.busy);
         if (bus.done) begin
            seen = 1'b1;
         end else if (inject && lat == 2) begin
            bus.start  = 1'b1;
            bus.portA  = 4'd1;
            bus.portB  = 4'd1;
            bus.opcode = 3'd0;
         end else begin
            bus.start = 1'b0;
         end
      end
      bus.start = 1'b0;
      check("latency", 32'(lat), 32'(exp_lat));
      check("busy_cycles", 32'(busy_cnt), 32'(exp_lat - 1));
      @(negedge clk);
      check("done_pulse", 32'(bus.done), 32'd0);
   endtask

   initial begin : main
      logic [3:0] prev;
      int         digit;
      int         guard;
      logic [15:0] shown;

      rst        = 1'b0;
      bus.start  = 1'b1;
      bus.portA  = 4'd1;
      bus.portB  = 4'd1;
      bus.opcode = 3'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_vis", 32'(bus.visualizar), 32'h0000);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_err", 32'(bus.err), 32'd0);
      check("rst_anode", 32'(anode), 32'b1110);
      check("rst_seg", 32'(sevenseg), 32'b0000001);
      bus.start = 1'b0;
      rst       = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("idle_busy", 32'(bus.busy), 32'd0);
      end

      do_op(4'd7, 4'd9, 3'd0, 1'b0);
      do_op(4'd15, 4'd15, 3'd2, 1'b1);
      do_op(4'd13, 4'd4, 3'd3, 1'b0);
      do_op(4'd5, 4'd0, 3'd3, 1'b0);
      repeat (3) @(negedge clk);
      check("err_hold", 32'(bus.err), 32'd1);
      check("vis_hold", 32'(bus.visualizar), 32'h005F);
      do_op(4'd3, 4'd5, 3'd1, 1'b0);

      shown = 16'h00FE;
      prev  = anode;
      guard = 0;
      @(negedge clk);
      while (!(anode == 4'b1101 && prev != 4'b1101) && guard < 64) begin
         prev = anode;
         @(negedge clk);
         guard++;
      end
      check("anode_found", 32'(guard < 64), 32'd1);
      for (int k = 0; k < 16; k++) begin
         if (k != 0) @(negedge clk);
         digit = (k / 4 + 1) % 4;
         check("anode_scan", 32'(anode), 32'(4'b1111 ^ (4'b0001 << digit)));
         check("seg_scan", 32'(sevenseg), 32'(seg_of(4'(shown >> (4 * digit)))));
      end

      for (int i = 0; i < 16; i++) begin
         do_op(4'($urandom), 4'($urandom), 3'($urandom_range(0, 7)), 1'b0);
      end
      do_op(4'd9, 4'd9, 3'd7, 1'b0);
      do_op(4'd0, 4'd0, 3'd3, 1'b0);

      @(negedge clk);
      bus.portA  = 4'd15;
      bus.portB  = 4'd15;
      bus.opcode = 3'd2;
      bus.start  = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("abort_busy", 32'(bus.busy), 32'd0);
      check("abort_done", 32'(bus.done), 32'd0);
      check("abort_vis", 32'(bus.visualizar), 32'h0000);
      check("abort_anode", 32'(anode), 32'b1110);
      rst = 1'b1;
      repeat (8) begin
         @(negedge clk);
         check("abort_idle", 32'(bus.busy), 32'd0);
      end

      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/alu_seq_display.md
ALU_SEQ_DISPLAY -- requirements
Module: alu_seq_display

Interface
REQ-001 Parameter WIDTH, default 4, operand width; legal range 2..8.
REQ-002 Parameter REFRESH_BITS, default 16, display refresh counter width; legal range 3..20.
REQ-003 Local RW = 2*WIDTH, internal result width.
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst  in  1  synchronous, active-low reset; sampled on rising clk only.
REQ-006 portA  in  WIDTH  operand A, unsigned.
REQ-007 portB  in  WIDTH  operand B, unsigned.
REQ-008 opcode  in  3  operation select, per REQ-014.
REQ-009 start  in  1  request; accepted only in IDLE.
REQ-010 busy  out  1  high while a multi-cycle operation runs.
REQ-011 done  out  1  one-cycle pulse when visualizar takes a new result.
REQ-012 err  out  1  divide-by-zero flag.
REQ-013 visualizar out 16 result, zero-extended from RW; sevenseg out [0:6] segments a..g, active-low; anode out 4 digit enables, active-low.

Function
REQ-014 Opcodes: 000 add, 001 sub, 010 mul, 011 div, 100 and, 101 or, 110 xor, 111 cmp.
REQ-015 FSM states IDLE, CALC, DONE; IDLE + start -> capture portA, portB, opcode; go to CALC for mul/div, DONE otherwise.
REQ-016 Single-cycle ops: start accepted at edge N; result and done=1 at edge N+1; DONE -> IDLE at the next edge.
REQ-017 mul: shift-add, one bit per cycle; busy=1 for exactly WIDTH cycles; result and done at edge N+WIDTH+1.
REQ-018 div: restoring, same timing as mul; quotient in result[WIDTH-1:0], remainder in result[RW-1:WIDTH].
REQ-019 div with B=0: no iteration; quotient all ones, remainder = A, err=1; timing as REQ-016.
REQ-020 err cleared on the next accepted start; otherwise held.
REQ-021 add: A+B zero-extended to RW (carry kept); sub: (A-B) mod 2^RW (3-5 gives all-ones minus 1).
REQ-022 and/or/xor: bitwise, zero-extended; cmp: result = {0..., A>B, A==B, A<B}, bits 2:0.
REQ-023 start while busy, in CALC or in DONE: ignored; operands not re-sampled.
REQ-024 Operand/opcode changes after acceptance do not affect the running operation.
REQ-025 visualizar holds the last result until the next done.
REQ-026 Refresh counter: REFRESH_BITS wide, free-running, wraps to 0.
REQ-027 Digit index = counter[REFRESH_BITS-1:REFRESH_BITS-2]; each digit held 2^(REFRESH_BITS-2) cycles.
REQ-028 anode = one-hot active-low of index (0 -> 1110, 3 -> 0111); digit i shows hex nibble visualizar[4i+3:4i].
REQ-029 Hex segment codes [a..g], active-low: 0=0000001, 1=1001111, 8=0000000, E=0110000, F=0111000; others standard.
REQ-030 sevenseg and anode registered; both change on the same edge.

Reset
REQ-031 rst=0 at an edge: state IDLE, busy=0, done=0, err=0, visualizar=0, refresh counter=0.
REQ-032 Display after reset: anode=1110, sevenseg=0000001.
REQ-033 Reset during CALC aborts: no done pulse; visualizar=0.
REQ-034 start with rst=0 at the same edge is ignored.

Verification (WIDTH=4, REFRESH_BITS=4)
REQ-035 Reset held 3 cycles -> visualizar=0x0000, busy=0, done=0, err=0, anode=1110, sevenseg=0000001.
REQ-036 A=7, B=9, add, start at edge N -> done=1 only at N+1, visualizar=0x0010, busy never high.
REQ-037 A=15, B=15, mul -> busy high for 4 cycles, done at N+5, visualizar=0x00E1; start pulsed mid-run is ignored.
REQ-038 A=13, B=4, div -> visualizar=0x0013, err=0; then A=5, B=0, div -> visualizar=0x005F, err=1 until the next start.
REQ-039 A=3, B=5, sub -> visualizar=0x00FE; anode steps 1110, 1101, 1011, 0111, 4 cycles each, then wraps.
REQ-040 rst=0 two cycles into a mul -> no done pulse, busy=0 at the next edge, visualizar=0x0000.
